march_sequencer: RTL and testbench
==================================

Name: march_sequencer

Overview:
- Self-contained March C- controller for the BIST memory datapath.
- Sequences address, read/write strobes and the data background over the whole memory.
- Checks read data one cycle after each read, records the first failure, and reports done/fail.
- Replaces the ad-hoc controller/address-generator pairing with a single scheduler that owns the memory port during test.

Parameters:
- a_width, 4, address width; memory depth N = 2**a_width.
- width, 4, data word width.
- stop_on_fail, 0, 1 = abort to DONE on first mismatch; 0 = run the full algorithm.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  level sampled each cycle; begins a test when in IDLE or DONE.
- mem_addr  output  a_width  memory address.
- mem_wr  output  1  write strobe; one cycle per write.
- mem_rd  output  1  read strobe; data returned on mem_rdata in the next cycle.
- mem_wdata  output  width  write data: all-0 or all-1 background.
- mem_rdata  input  width  read data, valid the cycle after mem_rd.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- fail  output  1  sticky mismatch flag.
- fail_addr  output  a_width  address of the first mismatch.
- fail_elem  output  3  March element index (0-5) of the first mismatch.
- fail_data  output  width  mem_rdata captured at the first mismatch.

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs 0, including mem_wr/mem_rd immediately. Counters and capture registers cleared.
- March C- elements and address order:
  - e0 up w0
  - e1 up r0,w1
  - e2 up r1,w0
  - e3 down r0,w1
  - e4 down r1,w0
  - e5 up r0
- Up order runs 0..N-1; down order runs N-1..0.
- IDLE/DONE + start=1: at the next edge go to RUN and clear fail, fail_* and done. The first op (e0 w0 @0) is driven in the first RUN cycle.
- RUN: exactly one op per cycle, no bubbles.
  - Two-op elements issue op0 then op1 at the same address, then advance the address.
  - After the last address of an element, the next cycle issues the first op of the next element at its start address.
  - Total 10N op cycles (80 writes, 80 reads at N=16).
- Read check:
  - Each read registers the expected value (all-0/all-1), address and element.
  - In the following cycle, mem_rdata is compared to the expected value.
  - On the first mismatch (fail=0): set fail, and capture fail_addr, fail_elem and fail_data from the registered values.
  - Later mismatches do not change the captured values.
- After the last op (e5 r0 @N-1): one DRAIN cycle for its compare, then DONE.
- DONE: done=1, busy=0; hold fail/fail_* until the next start.
- stop_on_fail=1: a mismatch detected in RUN moves to DONE at the next edge.
  - The op issued in the detection cycle completes normally.
  - No further ops are issued.
- start while busy is ignored.
- mem_wr and mem_rd are never high together.
- mem_addr holds its last value when idle.
- rst asserted mid-run aborts immediately to IDLE. No partial results are retained.

Decomposition:
- Shared package bist_pkg:
  - element count constant (6)
  - element index encoding
  - per-element table function returning op count, op types, data value and direction
  - state enum (IDLE, RUN, DRAIN, DONE)
- Sub-module march_addr_counter: up/down counter with load-start-address and terminal-count flag, parameterised by a_width.

Test Plan:
- Fault-free 16x4 memory model, start pulse: done=1 exactly 162 cycles after the start-sampling edge, fail=0, 80 mem_wr and 80 mem_rd pulses, no overlap of mem_wr and mem_rd.
- Bit0 stuck-at-1 at address 5, stop_on_fail=0: fail=1, fail_addr=5, fail_elem=1, fail_data=4'b0001, done still at cycle 162.
- Bit3 stuck-at-0 at address 15 (writes of 1 lost): fail_elem=2, fail_addr=15, fail_data=4'b0111.
- Same fault as the bit0 case with stop_on_fail=1: done within 2 cycles of the mismatching read, no mem_wr/mem_rd after DONE.
- rst pulsed low at cycle 50 of a run: outputs 0 asynchronously, state IDLE. A new start then gives a clean fault-free result.
- start held high during RUN has no effect. A restart from DONE after a failing run clears fail and fail_* before the new run completes clean.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared March C- definitions: states, element encoding and the
// per-element operation table used by the sequencer.
package bist_pkg;

  localparam int n_elem = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    EL_W0      = 3'd0,
    EL_R0W1_UP = 3'd1,
    EL_R1W0_UP = 3'd2,
    EL_R0W1_DN = 3'd3,
    EL_R1W0_DN = 3'd4,
    EL_R0      = 3'd5
  } elem_t;

  localparam logic [2:0] elem_last = EL_R0;

  typedef struct packed {
    logic two_ops;
    logic wr0;
    logic wr1;
    logic d0;
    logic d1;
    logic down;
  } elem_info_t;

  // d0/d1 are the write value or the expected read value of each op
  function automatic elem_info_t elem_info(input logic [2:0] e);
    elem_info_t i;
    i = '0;
    unique case (e)
      EL_W0:      i = 6'b010000;
      EL_R0W1_UP: i = 6'b101010;
      EL_R1W0_UP: i = 6'b101100;
      EL_R0W1_DN: i = 6'b101011;
      EL_R1W0_DN: i = 6'b101101;
      EL_R0:      i = 6'b000000;
      default:    i = 6'b000000;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/march_addr_counter.sv
// Up/down address counter with start-address load and
// terminal-count flag for the current direction.
module march_addr_counter #(
  parameter int a_width = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               load_down,
  input  logic               step,
  input  logic               down,
  output logic [a_width-1:0] addr,
  output logic               tc
);

  localparam logic [a_width-1:0] one = 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - one : addr + one;
    end
  end

  assign tc = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/march_sequencer.sv
// March C- BIST scheduler: drives the memory port, checks reads one
// cycle later and records the first failure.
module march_sequencer
  import bist_pkg::*;
#(
  parameter int a_width      = 4,
  parameter int width        = 4,
  parameter int stop_on_fail = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [a_width-1:0] mem_addr,
  output logic               mem_wr,
  output logic               mem_rd,
  output logic [width-1:0]   mem_wdata,
  input  logic [width-1:0]   mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [a_width-1:0] fail_addr,
  output logic [2:0]         fail_elem,
  output logic [width-1:0]   fail_data
);

  state_t             state, state_n;
  logic [2:0]         elem, elem_n;
  logic               op_sel, op_sel_n;
  elem_info_t         info, info_n;
  logic               ld, ld_down, step, tc;
  logic [a_width-1:0] addr;
  logic               issue, cur_wr, cur_d;
  logic               last_op, go, mismatch;

  logic               chk_v;
  logic [width-1:0]   chk_exp;
  logic [a_width-1:0] chk_addr;
  logic [2:0]         chk_elem;

  march_addr_counter #(.a_width(a_width)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_down(ld_down),
    .step     (step),
    .down     (info.down),
    .addr     (addr),
    .tc       (tc)
  );

  always_comb begin
    info     = elem_info(elem);
    info_n   = elem_info(elem + 3'd1);
    issue    = (state == RUN);
    cur_wr   = op_sel ? info.wr1 : info.wr0;
    cur_d    = op_sel ? info.d1 : info.d0;
    last_op  = !info.two_ops || op_sel;
    go       = ((state == IDLE) || (state == DONE)) && start;
    mismatch = chk_v && (mem_rdata != chk_exp);
  end

  always_comb begin
    state_n  = state;
    elem_n   = elem;
    op_sel_n = op_sel;
    ld       = 1'b0;
    ld_down  = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = RUN;
          elem_n   = 3'd0;
          op_sel_n = 1'b0;
          ld       = 1'b1;
        end
      end
      RUN: begin
        if ((stop_on_fail != 0) && mismatch) begin
          state_n = DONE;
        end else if (!last_op) begin
          op_sel_n = 1'b1;
        end else begin
          op_sel_n = 1'b0;
          if (!tc) begin
            step = 1'b1;
          end else if (elem == elem_last) begin
            state_n = DRAIN;
          end else begin
            elem_n  = elem + 3'd1;
            ld      = 1'b1;
            ld_down = info_n.down;
          end
        end
      end
      DRAIN:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      elem   <= 3'd0;
      op_sel <= 1'b0;
    end else begin
      state  <= state_n;
      elem   <= elem_n;
      op_sel <= op_sel_n;
    end
  end

  // read context is registered so the compare lines up with mem_rdata
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_v     <= 1'b0;
      chk_exp   <= '0;
      chk_addr  <= '0;
      chk_elem  <= 3'd0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
      fail_data <= '0;
    end else begin
      chk_v <= issue && !cur_wr;
      if (issue && !cur_wr) begin
        chk_exp  <= {width{cur_d}};
        chk_addr <= addr;
        chk_elem <= elem;
      end
      if (go) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= 3'd0;
        fail_data <= '0;
      end else if (mismatch && !fail) begin
        fail      <= 1'b1;
        fail_addr <= chk_addr;
        fail_elem <= chk_elem;
        fail_data <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr;
  assign mem_wr    = issue && cur_wr;
  assign mem_rd    = issue && !cur_wr;
  assign mem_wdata = (issue && cur_wr) ? {width{cur_d}} : '0;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_march_sequencer.sv
// Bench for march_sequencer: two instances (run-to-end and
// stop-on-fail) against a 16x4 memory model with injectable faults.
module tb_march_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] addr0, addr1, wdata0, wdata1;
  logic [3:0] rdata0 = '0, rdata1 = '0;
  logic       wr0, wr1, rd0, rd1, busy0, busy1, done0, done1;
  logic       fail0, fail1;
  logic [3:0] faddr0, faddr1, fdata0, fdata1;
  logic [2:0] felem0, felem1;

  march_sequencer #(.a_width(4), .width(4), .stop_on_fail(0)) u_dut (
    .clk(clk), .rst(rst), .start(start0),
    .mem_addr(addr0), .mem_wr(wr0), .mem_rd(rd0),
    .mem_wdata(wdata0), .mem_rdata(rdata0),
    .busy(busy0), .done(done0), .fail(fail0),
    .fail_addr(faddr0), .fail_elem(felem0), .fail_data(fdata0)
  );

  march_sequencer #(.a_width(4), .width(4), .stop_on_fail(1)) u_stop (
    .clk(clk), .rst(rst), .start(start1),
    .mem_addr(addr1), .mem_wr(wr1), .mem_rd(rd1),
    .mem_wdata(wdata1), .mem_rdata(rdata1),
    .busy(busy1), .done(done1), .fail(fail1),
    .fail_addr(faddr1), .fail_elem(felem1), .fail_data(fdata1)
  );

  logic [3:0] mem0 [16];
  logic [3:0] mem1 [16];
  int fault = 0;

  // 1: bit0 stuck-at-1 @5, 2: bit3 stuck-at-0 @15
  function automatic logic [3:0] flt(input logic [3:0] v,
                                     input logic [3:0] a);
    logic [3:0] r;
    r = v;
    if (fault == 1 && a == 4'd5)  r[0] = 1'b1;
    if (fault == 2 && a == 4'd15) r[3] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (wr0) mem0[addr0] <= wdata0;
    if (rd0) rdata0 <= flt(mem0[addr0], addr0);
    if (wr1) mem1[addr1] <= wdata1;
    if (rd1) rdata1 <= flt(mem1[addr1], addr1);
  end

  bit sel = 1'b0;
  logic s_wr, s_rd, s_done, s_fail;
  logic [3:0] s_faddr, s_fdata;
  logic [2:0] s_felem;
  assign s_wr    = sel ? wr1 : wr0;
  assign s_rd    = sel ? rd1 : rd0;
  assign s_done  = sel ? done1 : done0;
  assign s_fail  = sel ? fail1 : fail0;
  assign s_faddr = sel ? faddr1 : faddr0;
  assign s_felem = sel ? felem1 : felem0;
  assign s_fdata = sel ? fdata1 : fdata0;

  int nwr = 0, nrd = 0, novl = 0, npost = 0;
  always @(negedge clk) begin
    if (s_wr) nwr++;
    if (s_rd) nrd++;
    if ((wr0 && rd0) || (wr1 && rd1)) novl++;
    if (s_done && (s_wr || s_rd)) npost++;
  end

  typedef struct {
    bit         sel;
    int         fault;
    logic       fail;
    logic [3:0] faddr;
    logic [2:0] felem;
    logic [3:0] fdata;
    int         cyc;
    int         nwr;
    int         nrd;
  } scn_t;

  scn_t tbl [5];
  scn_t sb [$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // cyc counts rising edges from the start-sampling edge (inclusive)
  // up to the edge after which done is seen high
  task automatic run(input scn_t s, input bit hold, input bit chk_clear);
    scn_t e;
    int n;
    bit seen;
    sel = s.sel;
    fault = s.fault;
    sb.push_back(s);
    @(negedge clk);
    nwr = 0; nrd = 0; novl = 0; npost = 0;
    if (!s.sel) start0 = 1'b1;
    else start1 = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (!hold) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      if (chk_clear && n == 1) begin
        check("clear_fail", s_fail, 0);
        check("clear_addr", s_faddr, 0);
        check("clear_elem", s_felem, 0);
        check("clear_data", s_fdata, 0);
      end
      if (s_done) seen = 1'b1;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    check("done_seen", seen, 1);
    e = sb.pop_front();
    check("cycles", n, e.cyc);
    check("fail", s_fail, e.fail);
    check("fail_addr", s_faddr, e.faddr);
    check("fail_elem", s_felem, e.felem);
    check("fail_data", s_fdata, e.fdata);
    repeat (4) @(negedge clk);
    check("wr_count", nwr, e.nwr);
    check("rd_count", nrd, e.nrd);
    check("overlap", novl, 0);
    check("ops_after_done", npost, 0);
    check("done_hold", s_done, 1);
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 4'd0,  3'd0, 4'h0, 162, 80, 80};
    tbl[1] = '{0, 1, 1, 4'd5,  3'd1, 4'h1, 162, 80, 80};
    tbl[2] = '{0, 2, 1, 4'd15, 3'd2, 4'h7, 162, 80, 80};
    tbl[3] = '{1, 1, 1, 4'd5,  3'd1, 4'h1, 29,  22, 6};
    tbl[4] = '{1, 0, 0, 4'd0,  3'd0, 4'h0, 162, 80, 80};

    #2 rst = 1'b0;
    #10;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_fail", fail0, 0);
    check("rst_wr", wr0, 0);
    check("rst_rd", rd0, 0);
    check("rst_addr", addr0, 0);
    check("rst_busy_stop", busy1, 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 5; i++) run(tbl[i], 1'b0, 1'b0);

    // asynchronous reset in the middle of a run
    sel = 1'b0;
    fault = 0;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (49) @(posedge clk);
    #3;
    check("mid_busy_before", busy0, 1);
    rst = 1'b0;
    #1;
    check("mid_busy", busy0, 0);
    check("mid_wr", wr0, 0);
    check("mid_rd", rd0, 0);
    check("mid_addr", addr0, 0);
    check("mid_done", done0, 0);
    @(negedge clk) rst = 1'b1;
    run(tbl[0], 1'b0, 1'b0);

    // start held high across the whole run
    run(tbl[0], 1'b1, 1'b0);
    check("addr_hold", addr0, 15);

    // failing run, then restart must clear the capture
    run(tbl[1], 1'b0, 1'b0);
    run(tbl[0], 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
